// File: rtl/test_pattern_gen_pkg.sv
// Shared definitions for the test pattern generator: MODE encodings,
// PRBS15 (x^15 + x^14 + 1) tap mask, seed and single-step helper.
package test_pattern_gen_pkg;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_PRBS  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_ZERO  = 2'd3;

  // Feedback taps on state bits 14 and 13 (x^15 and x^14 terms)
  localparam logic [14:0] PRBS_TAPS = 15'h6000;
  localparam logic [14:0] PRBS_SEED = 15'h7FFF;

  // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0
  function automatic logic [14:0] prbs15_step(input logic [14:0] state);
    return {state[13:0], ^(state & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/test_pattern_gen_lane.sv
// pattern_lane: one channel of the test pattern generator.
// Holds the ramp counter and (when TEST_PATTERN_PRBS_EN is defined) the
// PRBS15 LFSR for channel K, and selects the channel word for the current
// registered mode. Without TEST_PATTERN_PRBS_EN no LFSR is built and the
// PRBS mode selects zero.
module pattern_lane
  import test_pattern_gen_pkg::*;
#(
  parameter int          DATA_W  = 14,
  parameter int          TAG_W   = 4,
  parameter int unsigned TAG_VAL = 32'b1010,
  parameter int          K       = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              reload,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  output logic [DATA_W-1:0] lane_data
);

  localparam int               CNT_W    = DATA_W - TAG_W;
  localparam logic [CNT_W-1:0] CNT_SEED = CNT_W'(K);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TAG_W-1:0] TAG      = TAG_W'(TAG_VAL ^ K);

  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] prbs_data_s;

  // Ramp counter: reload wins over advance, hold while blanked
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= CNT_SEED;
    end else if (reload) begin
      cnt_r <= CNT_SEED;
    end else if (advance) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef TEST_PATTERN_PRBS_EN
  localparam logic [14:0] LFSR_SEED = PRBS_SEED ^ 15'(K);

  logic [14:0] lfsr_r;

  // PRBS15 state: same reload/advance/hold rules as the ramp counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr_r <= LFSR_SEED;
    end else if (reload) begin
      lfsr_r <= LFSR_SEED;
    end else if (advance) begin
      lfsr_r <= prbs15_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Narrow sample widths take the low state bits, wide ones zero-extend
  if (DATA_W > 15) begin : g_prbs_wide
    assign prbs_data_s = {{(DATA_W-15){1'b0}}, lfsr_r};
  end else begin : g_prbs_narrow
    assign prbs_data_s = lfsr_r[DATA_W-1:0];
  end
`else
  assign prbs_data_s = {DATA_W{1'b0}};
`endif

  // Channel word select for the active mode
  always_comb begin
    lane_data = {DATA_W{1'b0}};
    case (mode)
      MODE_RAMP:  lane_data = {cnt_r, TAG};
      MODE_PRBS:  lane_data = prbs_data_s;
      MODE_CONST: lane_data = const_val;
      MODE_ZERO:  lane_data = {DATA_W{1'b0}};
      default:    lane_data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/test_pattern_gen.sv
// test_pattern_gen: multi-channel test pattern source (ramp, PRBS15,
// constant, zero) with blanking via TRIG and restart via SYNC.
// Optional feature macro: TEST_PATTERN_PRBS_EN builds the per-channel
// PRBS15 generators; when undefined MODE=1 behaves as zero mode.
// The output mux follows the registered MODE so that a mode change first
// reloads the generators and the new mode appears starting from seed.
module test_pattern_gen
  import test_pattern_gen_pkg::*;
#(
  parameter int          DATA_W  = 14,
  parameter int          TAG_W   = 4,
  parameter int          NCH     = 2,
  parameter int unsigned TAG_VAL = 32'b1010
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TRIG,
  input  logic                  SYNC,
  input  logic [1:0]            MODE,
  input  logic [DATA_W-1:0]     CONST_VAL,
  output logic [NCH*DATA_W-1:0] DATA_OUT,
  output logic                  VALID_OUT
);

  logic                  trig_r;
  logic [1:0]            mode_r;
  logic                  reload_s;
  logic                  advance_s;
  logic                  valid_s;
  logic [NCH*DATA_W-1:0] lane_bus_s;

  // Register the blanking request and the previous MODE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trig_r <= 1'b0;
      mode_r <= MODE_RAMP;
    end else begin
      trig_r <= TRIG;
      mode_r <= MODE;
    end
  end

  // A SYNC pulse or any MODE change restarts every channel from seed
  assign reload_s  = SYNC | (MODE != mode_r);
  assign advance_s = ~trig_r;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    pattern_lane #(
      .DATA_W  (DATA_W),
      .TAG_W   (TAG_W),
      .TAG_VAL (TAG_VAL),
      .K       (k)
    ) u_lane (
      .CLK       (CLK),
      .RST       (RST),
      .reload    (reload_s),
      .advance   (advance_s),
      .mode      (mode_r),
      .const_val (CONST_VAL),
      .lane_data (lane_bus_s[k*DATA_W +: DATA_W])
    );
  end

  // Live-pattern flag: only modes that carry generated data, never while blanked
  always_comb begin
    valid_s = 1'b0;
    case (mode_r)
      MODE_RAMP:  valid_s = 1'b1;
`ifdef TEST_PATTERN_PRBS_EN
      MODE_PRBS:  valid_s = 1'b1;
`else
      MODE_PRBS:  valid_s = 1'b0;
`endif
      MODE_CONST: valid_s = 1'b1;
      MODE_ZERO:  valid_s = 1'b0;
      default:    valid_s = 1'b0;
    endcase
    if (trig_r) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_s;
    end
  end

  // Output register with blanking
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_OUT  <= {(NCH*DATA_W){1'b0}};
      VALID_OUT <= 1'b0;
    end else if (trig_r) begin
      DATA_OUT  <= {(NCH*DATA_W){1'b0}};
      VALID_OUT <= 1'b0;
    end else begin
      DATA_OUT  <= lane_bus_s;
      VALID_OUT <= valid_s;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen (default parameters).
// Reference model: per channel, the number of advances since the last
// seed load; the expected word is computed arithmetically from that count.
module tb_test_pattern_gen;

  localparam int DW = 14;
  localparam int TW = 4;
  localparam int NC = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             TRIG;
  logic             SYNC;
  logic [1:0]       MODE;
  logic [DW-1:0]    CONST_VAL;
  logic [NC*DW-1:0] DATA_OUT;
  logic             VALID_OUT;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic             m_trig;
  logic [1:0]       m_mode;
  int               m_n [NC];
  logic [NC*DW-1:0] m_data;
  logic             m_valid;

  always #5 CLK = ~CLK;

  test_pattern_gen #(
    .DATA_W  (DW),
    .TAG_W   (TW),
    .NCH     (NC),
    .TAG_VAL (32'b1010)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .TRIG      (TRIG),
    .SYNC      (SYNC),
    .MODE      (MODE),
    .CONST_VAL (CONST_VAL),
    .DATA_OUT  (DATA_OUT),
    .VALID_OUT (VALID_OUT)
  );

`ifdef TEST_PATTERN_PRBS_EN
  function automatic logic [14:0] ref_prbs(input int k, input int n);
    logic [14:0] s;
    s = 15'h7FFF ^ 15'(k);
    for (int i = 0; i < n; i++) s = {s[13:0], s[14] ^ s[13]};
    return s;
  endfunction
`endif

  function automatic logic [DW-1:0] ref_word(input int k, input logic [1:0] md,
                                             input int n, input logic [DW-1:0] cv);
    int cnt;
    int tag;
    cnt = (k + n) % (1 << (DW - TW));
    tag = (10 ^ k) % (1 << TW);
    case (md)
      2'd0: return DW'(cnt * (1 << TW) + tag);
`ifdef TEST_PATTERN_PRBS_EN
      2'd1: return DW'(ref_prbs(k, n));
`endif
      2'd2: return cv;
      default: return {DW{1'b0}};
    endcase
  endfunction

  task automatic model_reset();
    m_trig  = 1'b0;
    m_mode  = 2'd0;
    m_data  = '0;
    m_valid = 1'b0;
    for (int k = 0; k < NC; k++) m_n[k] = 0;
  endtask

  // Apply one rising edge to the model using the inputs present at that edge
  task automatic model_edge();
    logic reload;
    logic live_mode;
    for (int k = 0; k < NC; k++)
      m_data[k*DW +: DW] = m_trig ? {DW{1'b0}} : ref_word(k, m_mode, m_n[k], CONST_VAL);
    live_mode = (m_mode == 2'd0) || (m_mode == 2'd2);
`ifdef TEST_PATTERN_PRBS_EN
    live_mode = live_mode || (m_mode == 2'd1);
`endif
    m_valid = !m_trig && live_mode;
    reload = SYNC || (MODE != m_mode);
    for (int k = 0; k < NC; k++) begin
      if (reload) m_n[k] = 0;
      else if (!m_trig) m_n[k] = m_n[k] + 1;
    end
    m_trig = TRIG;
    m_mode = MODE;
  endtask

  task automatic clk_step();
    @(posedge CLK);
    #1;
    model_edge();
  endtask

  task automatic test_reset();
    RST = 1'b1; TRIG = 1'b0; SYNC = 1'b0; MODE = 2'd0; CONST_VAL = '0;
    model_reset();
    #12;
    total++;
    if (DATA_OUT !== '0 || VALID_OUT !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: data=%h valid=%b expected data=0 valid=0", DATA_OUT, VALID_OUT);
    end
    @(posedge CLK);
    #3;
    RST = 1'b0;
    clk_step();
    total++;
    if (DATA_OUT[0 +: DW] !== 14'h000A || DATA_OUT[DW +: DW] !== 14'h001B || VALID_OUT !== 1'b1) begin
      bad++;
      $display("FAIL first_ramp: ch0=%h ch1=%h valid=%b expected ch0=000a ch1=001b valid=1",
               DATA_OUT[0 +: DW], DATA_OUT[DW +: DW], VALID_OUT);
    end
    clk_step();
    total++;
    if (DATA_OUT[0 +: DW] !== 14'h001A || DATA_OUT[DW +: DW] !== 14'h002B) begin
      bad++;
      $display("FAIL second_ramp: ch0=%h ch1=%h expected ch0=001a ch1=002b",
               DATA_OUT[0 +: DW], DATA_OUT[DW +: DW]);
    end
  endtask

  task automatic test_ramp_wrap();
    logic [DW-1:0] prev;
    bit            wrapped;
    wrapped = 1'b0;
    prev = DATA_OUT[0 +: DW];
    for (int i = 0; i < 1030; i++) begin
      clk_step();
      total++;
      if (DATA_OUT !== m_data || VALID_OUT !== 1'b1) begin
        bad++;
        $display("FAIL ramp_run[%0d]: data=%h valid=%b expected data=%h valid=1",
                 i, DATA_OUT, VALID_OUT, m_data);
      end
      if (prev == 14'h3FFA && DATA_OUT[0 +: DW] == 14'h000A) wrapped = 1'b1;
      prev = DATA_OUT[0 +: DW];
    end
    total++;
    if (!wrapped) begin
      bad++;
      $display("FAIL ramp_wrap: wrap seen=%0d expected 1", wrapped);
    end
  endtask

  task automatic test_trig_burst();
    logic [DW-1:0] s0;
    int            blanked;
    blanked = 0;
    TRIG = 1'b1;
    clk_step();
    s0 = DATA_OUT[0 +: DW];
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) TRIG = 1'b0;
      clk_step();
      total++;
      if (DATA_OUT !== m_data || VALID_OUT !== m_valid) begin
        bad++;
        $display("FAIL trig_burst[%0d]: data=%h valid=%b expected data=%h valid=%b",
                 i, DATA_OUT, VALID_OUT, m_data, m_valid);
      end
      if (DATA_OUT == '0 && VALID_OUT == 1'b0) blanked++;
      if (i == 6) begin
        total++;
        if (DATA_OUT[0 +: DW] !== DW'(s0 + 14'h0010)) begin
          bad++;
          $display("FAIL trig_resume: ch0=%h expected %h", DATA_OUT[0 +: DW], DW'(s0 + 14'h0010));
        end
      end
    end
    total++;
    if (blanked != 5) begin
      bad++;
      $display("FAIL trig_blank_len: blanked=%0d expected 5", blanked);
    end
  endtask

  task automatic test_const();
    MODE = 2'd2;
    CONST_VAL = 14'h1234;
    clk_step();
    clk_step();
    total++;
    if (DATA_OUT[0 +: DW] !== 14'h1234 || DATA_OUT[DW +: DW] !== 14'h1234 || VALID_OUT !== 1'b1) begin
      bad++;
      $display("FAIL const_mode: data=%h valid=%b expected 1234 on both channels, valid=1",
               DATA_OUT, VALID_OUT);
    end
    for (int i = 0; i < 20; i++) begin
      CONST_VAL = DW'($urandom);
      clk_step();
      total++;
      if (DATA_OUT !== m_data || VALID_OUT !== m_valid) begin
        bad++;
        $display("FAIL const_rand[%0d]: data=%h valid=%b expected data=%h valid=%b",
                 i, DATA_OUT, VALID_OUT, m_data, m_valid);
      end
    end
    MODE = 2'd0;
    clk_step();
    clk_step();
    total++;
    if (DATA_OUT[0 +: DW] !== 14'h000A || DATA_OUT[DW +: DW] !== 14'h001B) begin
      bad++;
      $display("FAIL const_to_ramp: ch0=%h ch1=%h expected ch0=000a ch1=001b",
               DATA_OUT[0 +: DW], DATA_OUT[DW +: DW]);
    end
  endtask

  task automatic test_prbs();
    MODE = 2'd1;
    clk_step();
    clk_step();
    total++;
`ifdef TEST_PATTERN_PRBS_EN
    if (DATA_OUT[0 +: DW] !== 14'h3FFF || VALID_OUT !== 1'b1) begin
      bad++;
      $display("FAIL prbs_seed: ch0=%h valid=%b expected ch0=3fff valid=1", DATA_OUT[0 +: DW], VALID_OUT);
    end
`else
    if (DATA_OUT !== '0 || VALID_OUT !== 1'b0) begin
      bad++;
      $display("FAIL prbs_disabled: data=%h valid=%b expected data=0 valid=0", DATA_OUT, VALID_OUT);
    end
`endif
    for (int i = 0; i < 40; i++) begin
      clk_step();
      total++;
      if (DATA_OUT !== m_data || VALID_OUT !== m_valid) begin
        bad++;
        $display("FAIL prbs_run[%0d]: data=%h valid=%b expected data=%h valid=%b",
                 i, DATA_OUT, VALID_OUT, m_data, m_valid);
      end
    end
  endtask

  task automatic test_sync();
    MODE = 2'd0;
    for (int i = 0; i < 6; i++) clk_step();
    SYNC = 1'b1;
    clk_step();
    SYNC = 1'b0;
    clk_step();
    total++;
    if (DATA_OUT[0 +: DW] !== 14'h000A || DATA_OUT[DW +: DW] !== 14'h001B) begin
      bad++;
      $display("FAIL sync_restart: ch0=%h ch1=%h expected ch0=000a ch1=001b",
               DATA_OUT[0 +: DW], DATA_OUT[DW +: DW]);
    end
    // SYNC together with TRIG: reload happens, output stays blanked
    for (int i = 0; i < 4; i++) clk_step();
    SYNC = 1'b1;
    TRIG = 1'b1;
    clk_step();
    SYNC = 1'b0;
    clk_step();
    total++;
    if (DATA_OUT !== '0 || VALID_OUT !== 1'b0) begin
      bad++;
      $display("FAIL sync_trig_blank: data=%h valid=%b expected data=0 valid=0", DATA_OUT, VALID_OUT);
    end
    TRIG = 1'b0;
    clk_step();
    clk_step();
    total++;
    if (DATA_OUT[0 +: DW] !== 14'h000A || DATA_OUT !== m_data) begin
      bad++;
      $display("FAIL sync_trig_resume: data=%h expected ch0=000a data=%h", DATA_OUT, m_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      TRIG = ($urandom_range(0, 3) == 0);
      SYNC = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 19) == 0) MODE = 2'($urandom_range(0, 3));
      CONST_VAL = DW'($urandom);
      clk_step();
      total++;
      if (DATA_OUT !== m_data || VALID_OUT !== m_valid) begin
        bad++;
        $display("FAIL random[%0d]: data=%h valid=%b expected data=%h valid=%b",
                 i, DATA_OUT, VALID_OUT, m_data, m_valid);
      end
    end
    TRIG = 1'b0;
    SYNC = 1'b0;
  endtask

  task automatic test_async_reset();
    MODE = 2'd0;
    for (int i = 0; i < 5; i++) clk_step();
    #2;
    RST = 1'b1;
    #1;
    total++;
    if (DATA_OUT !== '0 || VALID_OUT !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: data=%h valid=%b expected data=0 valid=0", DATA_OUT, VALID_OUT);
    end
    model_reset();
    #2;
    RST = 1'b0;
    clk_step();
    total++;
    if (DATA_OUT[0 +: DW] !== 14'h000A || DATA_OUT[DW +: DW] !== 14'h001B || VALID_OUT !== 1'b1) begin
      bad++;
      $display("FAIL reset_restart: ch0=%h ch1=%h valid=%b expected ch0=000a ch1=001b valid=1",
               DATA_OUT[0 +: DW], DATA_OUT[DW +: DW], VALID_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_wrap();
    test_trig_burst();
    test_const();
    test_prbs();
    test_sync();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
